// File: rtl/updown_count_decoder_if.sv
// Bus between the counter-observing side and the direction decoder.
// The master drives samples; the slave (decoder) returns decoded direction and status.
interface updown_count_decoder_if #(
  parameter int WIDTH = 3,
  parameter int POS_W = 8,
  parameter int ERR_W = 4
);
  // cnt_valid qualifies cnt_in for exactly one cycle; there is no ready, so the
  // decoder accepts every valid sample, and every output is a registered result.
  logic             cnt_valid;
  logic [WIDTH-1:0] cnt_in;
  logic             pos_clr;
  logic             dir_valid;
  logic             dir_out;
  logic             err;
  logic             locked;
  logic [ERR_W-1:0] err_count;
  logic [POS_W-1:0] pos;
  logic [1:0]       state_dbg;

  modport master (
    output cnt_valid, cnt_in, pos_clr,
    input  dir_valid, dir_out, err, locked, err_count, pos, state_dbg
  );

  modport slave (
    input  cnt_valid, cnt_in, pos_clr,
    output dir_valid, dir_out, err, locked, err_count, pos, state_dbg
  );
endinterface

// File: rtl/updown_count_decoder.sv
// Observer for the up/down counter: regenerates step direction from successive
// count values, flags illegal jumps, tracks lock and accumulates displacement.
module updown_count_decoder #(
  parameter int WIDTH    = 3,
  parameter int LOCK_CNT = 4,
  parameter int POS_W    = 8,
  parameter int ERR_W    = 4
) (
  input logic clk,
  input logic rst,
  updown_count_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = 1;
  localparam logic [POS_W-1:0] POS_ONE = 1;
  localparam logic [ERR_W-1:0] ERR_ONE = 1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev, prev_nxt;
  logic [3:0]       run, run_nxt;
  logic             dv_r, dv_nxt;
  logic             dir_r, dir_nxt;
  logic             err_r, err_nxt;
  logic [ERR_W-1:0] errc_r, errc_nxt;
  logic [POS_W-1:0] pos_r, pos_nxt;

  logic [WIDTH-1:0] delta;
  logic             is_up, is_dn, is_stall;

  // Modular difference makes both wrap directions look like ordinary steps.
  assign delta    = bus.cnt_in - prev;
  assign is_up    = (delta == CNT_ONE);
  assign is_dn    = (delta == {WIDTH{1'b1}});
  assign is_stall = (delta == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      prev   <= '0;
      run    <= '0;
      dv_r   <= 1'b0;
      dir_r  <= 1'b0;
      err_r  <= 1'b0;
      errc_r <= '0;
      pos_r  <= '0;
    end else begin
      state  <= state_nxt;
      prev   <= prev_nxt;
      run    <= run_nxt;
      dv_r   <= dv_nxt;
      dir_r  <= dir_nxt;
      err_r  <= err_nxt;
      errc_r <= errc_nxt;
      pos_r  <= pos_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    run_nxt   = run;
    dv_nxt    = 1'b0;
    dir_nxt   = dir_r;
    err_nxt   = 1'b0;
    errc_nxt  = errc_r;
    pos_nxt   = pos_r;

    if (bus.cnt_valid) begin
      prev_nxt = bus.cnt_in;
      case (state)
        EMPTY: begin
          state_nxt = ACQ;
          run_nxt   = '0;
        end
        ACQ, LOCKED: begin
          if (is_up || is_dn) begin
            dv_nxt  = 1'b1;
            dir_nxt = is_up;
            pos_nxt = is_up ? (pos_r + POS_ONE) : (pos_r - POS_ONE);
            if (state == ACQ) begin
              run_nxt = run + 4'd1;
              if (run + 4'd1 == LOCK_N) state_nxt = LOCKED;
            end
          end else if (!is_stall) begin
            // Illegal jump: resync on the new value and start acquiring again.
            err_nxt   = 1'b1;
            errc_nxt  = (errc_r == ERR_MAX) ? errc_r : (errc_r + ERR_ONE);
            run_nxt   = '0;
            state_nxt = ACQ;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end

    if (bus.pos_clr) pos_nxt = '0;
  end

  assign bus.dir_valid = dv_r;
  assign bus.dir_out   = dir_r;
  assign bus.err       = err_r;
  assign bus.locked    = (state == LOCKED);
  assign bus.err_count = errc_r;
  assign bus.pos       = pos_r;
  assign bus.state_dbg = state;

endmodule
